// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Sole owner of the byte-wide parameter/image RAM port. Two requesters share it:
//   - a word writer (loader), and
//   - a byte/word reader (compute engine).
//   Each 16-bit word moves as two big-endian byte cycles: the high byte goes to addr and
//   the low byte goes to addr+1. When both requesters ask at once, the grant alternates
//   between them. After reset the write side wins the first tie.
//
// Ports
//   clk, RST              clock, synchronous active-high reset
//   wrReq/wrAddr/wrData   word write request (level, held until wrAck)
//   wrAck                 one-cycle pulse once the low byte has been written
//   rdReq/rdWord/rdAddr   read request (level, held until rdValid); rdWord=1 -> 16-bit
//   rdData/rdValid        read result (byte reads zero-extended), one-cycle valid pulse
//   ramAddress/ramDataIn  RAM address and write data (hold their value when idle)
//   ramDataOut            RAM read data, valid RD_LATENCY cycles after the read strobe
//   readSignal/writeSignal RAM strobes (never both high)
//   busy                  high whenever a transaction is in flight
module ram_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [15:0]       wrData,
  output logic              wrAck,
  input  logic              rdReq,
  input  logic              rdWord,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [15:0]       rdData,
  output logic              rdValid,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [7:0]        ramDataIn,
  input  logic [7:0]        ramDataOut,
  output logic              readSignal,
  output logic              writeSignal,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, WR_HI, WR_LO, RD_HI, RD_HI_W, RD_LO, RD_LO_W
  } state_t;

  // Wait-counter reload: the capture happens in the RD_*_W cycle where the count is zero.
  localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;      // latched transaction base address
  logic [7:0]        r_wr_lo;     // low byte of the write word
  logic              r_word;      // latched rdWord
  logic [7:0]        r_hi;        // high byte of a word read, held until the low byte arrives
  logic [1:0]        r_cnt;
  logic              r_last_rd;   // 1 = last grant went to the reader
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_din;
  logic              r_rd_stb;
  logic              r_wr_stb;
  logic              r_wr_ack;
  logic              r_rd_valid;
  logic [15:0]       r_rd_data;

  logic              w_grant_wr;
  logic              w_grant_rd;
  logic [ADDR_W-1:0] w_addr_p1;

  // On a tie, the side that did not win last time gets the grant.
  assign w_grant_wr = wrReq & (~rdReq | r_last_rd);
  assign w_grant_rd = rdReq & ~w_grant_wr;
  assign w_addr_p1  = r_addr + 1'b1;   // wraps modulo 2^ADDR_W

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wr_lo    <= '0;
      r_word     <= 1'b0;
      r_hi       <= '0;
      r_cnt      <= '0;
      r_last_rd  <= 1'b1;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_rd_stb   <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // Strobes and address are set up here, so they are registered and line up
          // with the state they belong to.
          if (w_grant_wr) begin
            r_addr     <= wrAddr;
            r_wr_lo    <= wrData[7:0];
            r_last_rd  <= 1'b0;
            r_ram_addr <= wrAddr;
            r_ram_din  <= wrData[15:8];
            r_wr_stb   <= 1'b1;
            r_state    <= WR_HI;
          end else if (w_grant_rd) begin
            r_addr     <= rdAddr;
            r_word     <= rdWord;
            r_last_rd  <= 1'b1;
            r_ram_addr <= rdAddr;
            r_rd_stb   <= 1'b1;
            r_state    <= RD_HI;
          end
        end
        WR_HI: begin
          r_ram_addr <= w_addr_p1;
          r_ram_din  <= r_wr_lo;
          r_wr_ack   <= 1'b1;   // lands in the low-byte cycle
          r_state    <= WR_LO;
        end
        WR_LO: begin
          r_wr_stb <= 1'b0;
          r_state  <= IDLE;
        end
        RD_HI: begin
          r_rd_stb <= 1'b0;
          r_cnt    <= LAT_M1;
          r_state  <= RD_HI_W;
        end
        RD_HI_W: begin
          if (r_cnt == 2'd0) begin
            if (r_word) begin
              r_hi       <= ramDataOut;
              r_ram_addr <= w_addr_p1;
              r_rd_stb   <= 1'b1;
              r_state    <= RD_LO;
            end else begin
              r_rd_data  <= {8'h00, ramDataOut};
              r_rd_valid <= 1'b1;
              r_state    <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RD_LO: begin
          r_rd_stb <= 1'b0;
          r_cnt    <= LAT_M1;
          r_state  <= RD_LO_W;
        end
        RD_LO_W: begin
          if (r_cnt == 2'd0) begin
            // rdData changes only on completion, so it holds the previous result meanwhile.
            r_rd_data  <= {r_hi, ramDataOut};
            r_rd_valid <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          r_rd_stb <= 1'b0;
          r_wr_stb <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign wrAck       = r_wr_ack;
  assign rdData      = r_rd_data;
  assign rdValid     = r_rd_valid;
  assign ramAddress  = r_ram_addr;
  assign ramDataIn   = r_ram_din;
  assign readSignal  = r_rd_stb;
  assign writeSignal = r_wr_stb;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at RD_LATENCY=1 backed by a 64 KiB
// byte RAM model, and one at RD_LATENCY=3 backed by a fixed-content read-only model.
module tb_ram_port_arbiter;

  logic        clk;
  logic        RST;
  // latency-1 instance
  logic        wrReq, wrAck, rdReq, rdWord, rdValid, readSignal, writeSignal, busy;
  logic [15:0] wrAddr, wrData, rdAddr, rdData, ramAddress;
  logic [7:0]  ramDataIn, ramDataOut;
  // latency-3 instance
  logic        wrReq3, wrAck3, rdReq3, rdWord3, rdValid3, readSignal3, writeSignal3, busy3;
  logic [15:0] wrAddr3, wrData3, rdAddr3, rdData3, ramAddress3;
  logic [7:0]  ramDataIn3, ramDataOut3;

  int n_chk  = 0;
  int n_fail = 0;

  ram_port_arbiter #(.ADDR_W(16), .RD_LATENCY(1)) dut (
    .clk(clk), .RST(RST),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrAck(wrAck),
    .rdReq(rdReq), .rdWord(rdWord), .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid),
    .ramAddress(ramAddress), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut),
    .readSignal(readSignal), .writeSignal(writeSignal), .busy(busy)
  );

  ram_port_arbiter #(.ADDR_W(16), .RD_LATENCY(3)) dut3 (
    .clk(clk), .RST(RST),
    .wrReq(wrReq3), .wrAddr(wrAddr3), .wrData(wrData3), .wrAck(wrAck3),
    .rdReq(rdReq3), .rdWord(rdWord3), .rdAddr(rdAddr3), .rdData(rdData3), .rdValid(rdValid3),
    .ramAddress(ramAddress3), .ramDataIn(ramDataIn3), .ramDataOut(ramDataOut3),
    .readSignal(readSignal3), .writeSignal(writeSignal3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, latency 1: data for the address seen at edge k appears after edge k.
  logic [7:0] mem1 [0:65535];
  logic [7:0] rd1_q;
  always @(posedge clk) begin
    if (writeSignal) mem1[ramAddress] <= ramDataIn;
    rd1_q <= mem1[ramAddress];
  end
  assign ramDataOut = rd1_q;

  // RAM model, latency 3: address 0x0005 holds 0x7E, everything else reads 0.
  logic [7:0] rd3_q [0:2];
  always @(posedge clk) begin
    rd3_q[0] <= (ramAddress3 == 16'h0005) ? 8'h7E : 8'h00;
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign ramDataOut3 = rd3_q[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int         cyc;
  int         ng;
  int         ovl;
  logic [3:0] gseq;
  logic       got;

  initial begin
    RST = 1'b1;
    wrReq = 0; wrAddr = 0; wrData = 0; rdReq = 0; rdWord = 0; rdAddr = 0;
    wrReq3 = 0; wrAddr3 = 0; wrData3 = 0; rdReq3 = 0; rdWord3 = 0; rdAddr3 = 0;
    step(); step();

    // reset state
    chk("rst_busy",   busy, 0);
    chk("rst_wstb",   writeSignal, 0);
    chk("rst_rstb",   readSignal, 0);
    chk("rst_wrack",  wrAck, 0);
    chk("rst_rdvld",  rdValid, 0);
    chk("rst_rddata", rdData, 0);
    chk("rst_addr",   ramAddress, 0);
    chk("rst_busy3",  busy3, 0);
    RST = 1'b0;

    // 1: write 0xABCD @0x000B
    wrReq = 1; wrAddr = 16'h000B; wrData = 16'hABCD;
    step();
    chk("t1_hi_wstb", writeSignal, 1);
    chk("t1_hi_addr", ramAddress, 16'h000B);
    chk("t1_hi_din",  ramDataIn, 8'hAB);
    chk("t1_hi_ack",  wrAck, 0);
    chk("t1_hi_busy", busy, 1);
    chk("t1_hi_rstb", readSignal, 0);
    step();
    chk("t1_lo_wstb", writeSignal, 1);
    chk("t1_lo_addr", ramAddress, 16'h000C);
    chk("t1_lo_din",  ramDataIn, 8'hCD);
    chk("t1_lo_ack",  wrAck, 1);
    chk("t1_lo_busy", busy, 1);
    wrReq = 0;
    step();
    chk("t1_end_wstb", writeSignal, 0);
    chk("t1_end_ack",  wrAck, 0);
    chk("t1_end_busy", busy, 0);
    chk("t1_mem_hi",   mem1[16'h000B], 8'hAB);
    chk("t1_mem_lo",   mem1[16'h000C], 8'hCD);

    // 2: word read @0x000B
    rdReq = 1; rdWord = 1; rdAddr = 16'h000B;
    step();
    chk("t2_hi_rstb", readSignal, 1);
    chk("t2_hi_addr", ramAddress, 16'h000B);
    chk("t2_hi_wstb", writeSignal, 0);
    step();
    chk("t2_hiw_rstb", readSignal, 0);
    chk("t2_hiw_vld",  rdValid, 0);
    step();
    chk("t2_lo_rstb", readSignal, 1);
    chk("t2_lo_addr", ramAddress, 16'h000C);
    step();
    chk("t2_low_vld", rdValid, 0);
    chk("t2_low_hold", rdData, 16'h0000);
    step();
    chk("t2_vld",  rdValid, 1);
    chk("t2_data", rdData, 16'hABCD);
    chk("t2_busy", busy, 0);
    rdReq = 0;
    step();
    chk("t2_vld_pulse", rdValid, 0);
    chk("t2_data_hold", rdData, 16'hABCD);

    // 3: both requests held from reset -> W,R,W,R
    RST = 1; wrReq = 1; wrAddr = 16'h0020; wrData = 16'h5A5A;
    rdReq = 1; rdWord = 0; rdAddr = 16'h000B;
    step();
    RST = 0;
    ng = 0; ovl = 0; gseq = 4'b0000;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      step();
      if (readSignal && writeSignal) ovl++;
      if (writeSignal && !wrAck) begin gseq[ng] = 1'b1; ng++; end
      else if (readSignal) begin gseq[ng] = 1'b0; ng++; end
    end
    chk("t3_ngrants", ng, 4);
    chk("t3_order",   gseq, 4'b0101);
    chk("t3_overlap", ovl, 0);
    wrReq = 0; rdReq = 0;
    for (int c = 0; c < 6; c++) step();
    chk("t3_idle", busy, 0);
    chk("t3_byte", rdData, 16'h00AB);

    // 4: write 0x1234 @0xFFFF wraps to 0x0000
    wrReq = 1; wrAddr = 16'hFFFF; wrData = 16'h1234;
    step();
    chk("t4_hi_addr", ramAddress, 16'hFFFF);
    chk("t4_hi_din",  ramDataIn, 8'h12);
    step();
    chk("t4_lo_addr", ramAddress, 16'h0000);
    chk("t4_lo_din",  ramDataIn, 8'h34);
    chk("t4_lo_ack",  wrAck, 1);
    wrReq = 0;
    step();
    chk("t4_mem_hi", mem1[16'hFFFF], 8'h12);
    chk("t4_mem_lo", mem1[16'h0000], 8'h34);
    rdReq = 1; rdWord = 1; rdAddr = 16'hFFFF;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (rdValid) got = 1;
    end
    chk("t4_rd_seen", got, 1);
    chk("t4_rd_data", rdData, 16'h1234);
    rdReq = 0;
    step();

    // 5: reset during WR_HI
    wrReq = 1; wrAddr = 16'h0040; wrData = 16'hBEEF;
    step();
    chk("t5_hi_wstb", writeSignal, 1);
    RST = 1; wrReq = 0;
    step();
    chk("t5_wstb", writeSignal, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ack",  wrAck, 0);
    RST = 0;
    step();
    chk("t5_ack2",  wrAck, 0);
    chk("t5_wstb2", writeSignal, 0);

    // 6: RD_LATENCY=3 byte read @0x0005
    rdReq3 = 1; rdWord3 = 0; rdAddr3 = 16'h0005;
    cyc = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      cyc++;
      if (rdValid3) got = 1;
    end
    rdReq3 = 0;
    chk("t6_seen",    got, 1);
    chk("t6_latency", cyc, 5);
    chk("t6_data",    rdData3, 16'h007E);
    step();
    chk("t6_pulse", rdValid3, 0);
    chk("t6_busy",  busy3, 0);
    chk("t6_noack", wrAck3, 0);
    chk("t6_nowr",  writeSignal3, 0);
    chk("t6_din",   ramDataIn3, 0);
    chk("t6_rstb",  readSignal3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
